// File: rtl/fourstate_pkg.sv
// Shared 4-state symbol encoding ({unk,val}) and pairwise combine helpers.
// Results never return z: an unknown operand yields x.
package fourstate_pkg;

  typedef logic [1:0] sym_t;

  localparam sym_t SYM_0 = 2'b00;
  localparam sym_t SYM_1 = 2'b01;
  localparam sym_t SYM_Z = 2'b10;
  localparam sym_t SYM_X = 2'b11;

  function automatic sym_t sym_and(input sym_t a, input sym_t b);
    if (a == SYM_0 || b == SYM_0) return SYM_0;
    if (a[1] || b[1]) return SYM_X;
    return SYM_1;
  endfunction

  function automatic sym_t sym_or(input sym_t a, input sym_t b);
    if (a == SYM_1 || b == SYM_1) return SYM_1;
    if (a[1] || b[1]) return SYM_X;
    return SYM_0;
  endfunction

  function automatic sym_t sym_xor(input sym_t a, input sym_t b);
    if (a[1] || b[1]) return SYM_X;
    return {1'b0, a[0] ^ b[0]};
  endfunction

endpackage

// File: rtl/fourstate_reduce.sv
// Combinational 4-state reduction AND/OR/XOR over aval/bval planes.
// Folds from the identity symbol of each operator; z collapses to x.
module fourstate_reduce
  import fourstate_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] aval,
  input  logic [WIDTH-1:0] bval,
  output logic [1:0]       red_and,
  output logic [1:0]       red_or,
  output logic [1:0]       red_xor
);

  always_comb begin
    red_and = SYM_1;
    red_or  = SYM_0;
    red_xor = SYM_0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      red_and = sym_and(red_and, {bval[i], aval[i]});
      red_or  = sym_or(red_or, {bval[i], aval[i]});
      red_xor = sym_xor(red_xor, {bval[i], aval[i]});
    end
  end

endmodule

// File: rtl/fourstate_deserializer.sv
// Bit-serial 4-state word receiver: collects WIDTH symbols MSB first and
// presents the planes plus registered reductions until the consumer accepts.
module fourstate_deserializer
  import fourstate_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sym,
  input  logic             in_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_aval,
  output logic [WIDTH-1:0] out_bval,
  output logic [1:0]       red_and,
  output logic [1:0]       red_or,
  output logic [1:0]       red_xor,
  output logic             drop
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] HOLD    = 1'b1;

  logic [0:0]       state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] sh_a, sh_a_n, sh_b, sh_b_n;
  logic [WIDTH-1:0] oa_n, ob_n;
  logic [1:0]       ra_n, ro_n, rx_n;
  logic             ov_n, drop_n;

  // Planes and count as they would be after accepting in_sym this cycle
  logic             restart;
  logic [WIDTH-1:0] wa, wb;
  logic [CW-1:0]    wcnt;
  logic [1:0]       w_and, w_or, w_xor;

  assign in_ready = (state == COLLECT);

  always_comb begin
    restart = in_first && (cnt != '0);
    if (restart) begin
      wa   = WIDTH'(in_sym[0]);
      wb   = WIDTH'(in_sym[1]);
      wcnt = CW'(1);
    end else begin
      wa   = (sh_a << 1) | WIDTH'(in_sym[0]);
      wb   = (sh_b << 1) | WIDTH'(in_sym[1]);
      wcnt = cnt + CW'(1);
    end
  end

  fourstate_reduce #(.WIDTH(WIDTH)) u_reduce (
    .aval    (wa),
    .bval    (wb),
    .red_and (w_and),
    .red_or  (w_or),
    .red_xor (w_xor)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_a_n  = sh_a;
    sh_b_n  = sh_b;
    oa_n    = out_aval;
    ob_n    = out_bval;
    ra_n    = red_and;
    ro_n    = red_or;
    rx_n    = red_xor;
    ov_n    = out_valid;
    drop_n  = 1'b0;
    case (state)
      COLLECT: begin
        if (in_valid) begin
          sh_a_n = wa;
          sh_b_n = wb;
          drop_n = restart;
          if (wcnt == CW'(WIDTH)) begin
            cnt_n   = '0;
            state_n = HOLD;
            ov_n    = 1'b1;
            oa_n    = wa;
            ob_n    = wb;
            ra_n    = w_and;
            ro_n    = w_or;
            rx_n    = w_xor;
          end else begin
            cnt_n = wcnt;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_n = COLLECT;
          ov_n    = 1'b0;
        end
      end
      default: state_n = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      cnt       <= '0;
      sh_a      <= '0;
      sh_b      <= '0;
      out_aval  <= '0;
      out_bval  <= '0;
      red_and   <= SYM_0;
      red_or    <= SYM_0;
      red_xor   <= SYM_0;
      out_valid <= 1'b0;
      drop      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sh_a      <= sh_a_n;
      sh_b      <= sh_b_n;
      out_aval  <= oa_n;
      out_bval  <= ob_n;
      red_and   <= ra_n;
      red_or    <= ro_n;
      red_xor   <= rx_n;
      out_valid <= ov_n;
      drop      <= drop_n;
    end
  end

endmodule

// File: tb/tb_fourstate_deserializer.sv
// Self-checking bench for fourstate_deserializer (WIDTH=4): directed cases
// plus random traffic against a symbol-queue reference model.
module tb_fourstate_deserializer;

  localparam int unsigned W = 4;
  localparam logic [1:0] S0 = 2'b00, S1 = 2'b01, SZ = 2'b10, SX = 2'b11;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_first, out_valid, out_ready, drop;
  logic [1:0]   in_sym, red_and, red_or, red_xor;
  logic [W-1:0] out_aval, out_bval;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [1:0]   q[$];
  logic         m_hold, m_valid, m_drop;
  logic [W-1:0] m_aval, m_bval;
  logic [1:0]   m_and, m_or, m_xor;

  fourstate_deserializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sym    (in_sym),
    .in_first  (in_first),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_aval  (out_aval),
    .out_bval  (out_bval),
    .red_and   (red_and),
    .red_or    (red_or),
    .red_xor   (red_xor),
    .drop      (drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_hold = 0; m_valid = 0; m_drop = 0;
    m_aval = '0; m_bval = '0;
    m_and = S0; m_or = S0; m_xor = S0;
  endtask

  // Word is complete: pack planes and derive reductions from symbol counts
  task automatic model_complete();
    int nz, n1, nu;
    nz = 0; n1 = 0; nu = 0;
    for (int i = 0; i < int'(W); i++) begin
      m_aval[W-1-i] = q[i][0];
      m_bval[W-1-i] = q[i][1];
      if (q[i] == S0) nz++;
      if (q[i] == S1) n1++;
      if (q[i][1]) nu++;
    end
    m_and = (nz > 0) ? S0 : (nu > 0) ? SX : S1;
    m_or  = (n1 > 0) ? S1 : (nu > 0) ? SX : S0;
    m_xor = (nu > 0) ? SX : ((n1 % 2) == 1 ? S1 : S0);
    m_valid = 1;
    m_hold = 1;
    q.delete();
  endtask

  task automatic compare_outputs();
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("out_aval", 64'(out_aval), 64'(m_aval));
    check("out_bval", 64'(out_bval), 64'(m_bval));
    check("red_and", 64'(red_and), 64'(m_and));
    check("red_or", 64'(red_or), 64'(m_or));
    check("red_xor", 64'(red_xor), 64'(m_xor));
    check("drop", 64'(drop), 64'(m_drop));
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge
  task automatic cycle(input logic v, input logic [1:0] s, input logic f, input logic r);
    in_valid = v; in_sym = s; in_first = f; out_ready = r;
    #1;
    check("in_ready", 64'(in_ready), 64'(!m_hold));
    m_drop = 0;
    if (!m_hold) begin
      if (v) begin
        if (f && q.size() != 0) begin
          q.delete();
          m_drop = 1;
        end
        q.push_back(s);
        if (q.size() == int'(W)) model_complete();
      end
    end else if (r) begin
      m_hold = 0;
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic send4(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                       input logic [1:0] d, input logic r);
    cycle(1, a, 1, r);
    cycle(1, b, 0, r);
    cycle(1, c, 0, r);
    cycle(1, d, 0, r);
  endtask

  task automatic expect_word(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [1:0] ra, input logic [1:0] ro, input logic [1:0] rx);
    check({tag, "_valid"}, 64'(out_valid), 64'(1));
    check({tag, "_aval"}, 64'(out_aval), 64'(a));
    check({tag, "_bval"}, 64'(out_bval), 64'(b));
    check({tag, "_and"}, 64'(red_and), 64'(ra));
    check({tag, "_or"}, 64'(red_or), 64'(ro));
    check({tag, "_xor"}, 64'(red_xor), 64'(rx));
  endtask

  initial begin
    rst_n = 0; in_valid = 0; in_sym = S0; in_first = 0; out_ready = 0;
    model_reset();
    #1;
    compare_outputs();
    check("reset_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    rst_n = 1;

    send4(S1, S0, S0, S1, 1);
    expect_word("w1001", 4'b1001, 4'b0000, S0, S1, S0);
    cycle(0, S0, 0, 1);
    check("w1001_one_cycle", 64'(out_valid), 64'(0));

    send4(SX, S0, S0, S1, 1);
    expect_word("wx001", 4'b1001, 4'b1000, S0, S1, SX);
    cycle(0, S0, 0, 1);

    send4(SZ, S1, S1, S1, 1);
    expect_word("wz111", 4'b0111, 4'b1000, SX, S1, SX);
    cycle(0, S0, 0, 1);
    send4(SZ, S0, S0, S0, 1);
    expect_word("wz000", 4'b0000, 4'b1000, S0, SX, SX);
    cycle(0, S0, 0, 1);

    // Restart mid-word discards the partial word
    cycle(1, S1, 1, 1);
    cycle(1, S1, 0, 1);
    cycle(1, S0, 1, 1);
    check("drop_pulse", 64'(drop), 64'(1));
    cycle(1, S1, 0, 1);
    check("drop_once", 64'(drop), 64'(0));
    cycle(1, S1, 0, 1);
    cycle(1, S0, 0, 1);
    expect_word("w0110", 4'b0110, 4'b0000, S0, S1, S0);
    cycle(0, S0, 0, 1);

    // Back-pressure: in_valid held while the word is parked
    send4(S1, S1, S0, S1, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, SX, 0, 0);
      expect_word("hold", 4'b1101, 4'b0000, S0, S1, S1);
    end
    cycle(1, SX, 0, 1);
    send4(SX, S1, S0, S1, 1);
    expect_word("after_hold", 4'b1101, 4'b1000, S0, S1, SX);
    cycle(0, S0, 0, 1);

    // Asynchronous reset mid-word with a previous word still registered
    send4(S1, S1, S1, S1, 0);
    cycle(1, S0, 0, 1);
    cycle(1, S1, 1, 1);
    cycle(1, S0, 0, 0);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    compare_outputs();
    check("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    rst_n = 1;
    send4(S0, S1, SZ, S1, 1);
    expect_word("post_rst", 4'b0101, 4'b0010, S0, S1, SX);
    cycle(0, S0, 0, 1);

    for (int i = 0; i < 400; i++) begin
      logic [1:0] s;
      s = 2'($urandom_range(0, 3));
      cycle($urandom_range(0, 3) != 0, s, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
